map_fetch_ctrl: RTL and testbench
=================================

MAP_FETCH_CTRL -- requirements
Module: map_fetch_ctrl

Interface
REQ-001 SHALL use one clock and synchronous, active-high reset.
REQ-002 SHALL have port `clk`, input, 1 bit: pixel clock.
REQ-003 SHALL have port `rst`, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port `sx`, input, 10 bits: current screen column from display timing.
REQ-005 SHALL have port `sy`, input, 10 bits: current screen row from display timing.
REQ-006 SHALL have port `de`, input, 1 bit: display-enable (active video).
REQ-007 SHALL have ports `ram_addr` (output, 10 bits), `ram_we` (output, 1 bit), `ram_wdata` (output, 4 bits) and `ram_rdata` (input, 4 bits): single-port tile RAM, 1-cycle read latency.
REQ-008 SHALL have ports `wr_req` (input, 1 bit), `wr_addr` (input, 10 bits), `wr_data` (input, 4 bits) and `wr_ack` (output, 1 bit): game-logic tile write handshake.
REQ-009 SHALL have ports `init_start` (input, 1 bit), `init_code` (input, 4 bits) and `init_done` (output, 1 bit): bulk map fill.
REQ-010 SHALL have ports `spr_code` (output, 4 bits), `spr_x` (output, 3 bits), `spr_y` (output, 3 bits) and `spr_valid` (output, 1 bit): feed to the tile sprite renderer.

Function
REQ-011 SHALL treat the map as 32x32 tiles of 8x8 px in pixels sx<256, sy<256; tile address = {sy[7:3], sx[7:3]}.
REQ-012 SHALL make a read slot exist exactly when de=1, sx<256, sy<256 and sx[2:0]=0; it drives ram_addr=tile address, ram_we=0.
REQ-013 SHALL register ram_rdata into the code register in the cycle after a read slot.
REQ-014 SHALL make spr_x, spr_y and spr_valid the sx[2:0], sy[2:0] and in-map&&de values delayed exactly 2 cycles; spr_code = code register.
REQ-015 SHALL give fixed latency: the pixel presented at cycle t appears on spr_* at t+2.
REQ-016 SHALL hold spr_code at 0 and spr_valid at 0 for out-of-map or blanking pixels.
REQ-017 SHALL treat every non-read-slot cycle as a free slot.
REQ-018 SHALL implement FSM states RUN and INIT.
REQ-019 SHALL, in RUN, when wr_req=1 in a free slot, drive ram_addr=wr_addr, ram_wdata=wr_data, ram_we=1 and assert wr_ack for that same cycle only (combinational grant, 1-cycle pulse).
REQ-020 SHALL require the requester to hold wr_req, wr_addr and wr_data stable until wr_ack; wr_req held after ack issues a second write.
REQ-021 SHALL never grant wr_req in a read slot; the display always wins.
REQ-022 SHALL make init_start in RUN enter INIT with a 10-bit fill counter = 0 and latch init_code.
REQ-023 SHALL make INIT write the latched code at the counter address in each free slot, then increment; wr_ack stays 0 in INIT.
REQ-024 SHALL, when the write at address 1023 occurs, pulse init_done for 1 cycle the next cycle and return to RUN.
REQ-025 SHALL ignore init_start while in INIT.
REQ-026 SHALL let init_start and wr_req in the same RUN free-slot cycle grant the write; INIT begins next cycle.
REQ-027 SHALL continue display reads during INIT; intermediate map contents may display.

Reset
REQ-028 SHALL make rst, in any state including mid-INIT, force RUN, counter=0, code register=0, delay pipeline cleared, and all outputs 0 (spr_*, wr_ack, init_done, ram_we, ram_addr, ram_wdata) from the next edge.
REQ-029 SHALL abandon a partial INIT on reset without resuming.

Structure
REQ-030 SHALL place the constants TILE_PX=8, MAP_COLS=32, MAP_ROWS=32 and MAP_AW=10, and the sprite-code enum (wall and corner codes, EMPTY), in shared package map_pkg.
REQ-031 SHALL contain no RAM itself; the natural sub-module is the external tile_ram (1024x4, single-port) instantiated beside it.
REQ-032 SHALL keep the FSM, fill counter, slot decode and the 2-stage delay within map_fetch_ctrl.

Verification
REQ-033 SHALL verify pixel timing: preload addr 33 = 4'h5, drive de=1, sy=8, sx=8..15 -> read at sx=8 with ram_addr=33; spr_code=5, spr_x 0..7, spr_y=0, spr_valid=1 two cycles after each pixel.
REQ-034 SHALL verify write blocking: wr_req with addr 100, data 4'h2 held while sx[2:0]=0, de=1 -> wr_ack=0 in that cycle; ack and write in the next cycle (sx[2:0]=1).
REQ-035 SHALL verify blanking writes: de=0 and three back-to-back requests -> three consecutive single-cycle acks, with RAM addresses matching.
REQ-036 SHALL verify init: init_start, init_code=4'h3 during blanking -> 1024 writes at addresses 0..1023, one init_done pulse, all RAM words = 3, zero wr_ack during INIT.
REQ-037 SHALL verify reset mid-init: rst after 200 fill writes -> state RUN, outputs 0 next cycle, no further fill writes, no init_done.
REQ-038 SHALL verify out-of-map pixels: sx=300, de=1 -> no read, spr_valid=0 and spr_code=0 two cycles later, and wr_req granted that cycle.

Source files
------------

// File: rtl/map_pkg.sv
// Shared tile-map geometry, sprite codes and fetch-controller types.
package map_pkg;

    localparam int TILE_PX  = 8;
    localparam int MAP_COLS = 32;
    localparam int MAP_ROWS = 32;
    localparam int MAP_AW   = 10;
    localparam int SCR_W    = 10;

    localparam int SUB_W = $clog2(TILE_PX);
    localparam int COL_W = $clog2(MAP_COLS);
    localparam int ROW_W = $clog2(MAP_ROWS);
    localparam int CODE_W = 4;

    // Pixel extent of the map on screen; anything at or beyond is off-map.
    localparam logic [SCR_W-1:0] MAP_W_PX = SCR_W'(MAP_COLS * TILE_PX);
    localparam logic [SCR_W-1:0] MAP_H_PX = SCR_W'(MAP_ROWS * TILE_PX);

    typedef enum logic [CODE_W-1:0] {
        EMPTY     = 4'h0,
        WALL_H    = 4'h1,
        WALL_V    = 4'h2,
        CORNER_TL = 4'h3,
        CORNER_TR = 4'h4,
        CORNER_BL = 4'h5,
        CORNER_BR = 4'h6
    } spr_code_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_INIT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [SUB_W-1:0] x;
        logic [SUB_W-1:0] y;
        logic             vld;
        logic             rd;
    } pix_t;

    function automatic logic [MAP_AW-1:0] tile_addr(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/map_fetch_ctrl.sv
// Tile-map fetch controller: arbitrates one tile RAM between display reads, game writes and bulk fill.
// Latency: pixel at cycle t appears on spr_* at t+2; writes are granted combinationally in free slots.
// Backpressure: display reads always win; wr_req waits (no ack) until a free slot, fill pauses likewise.
module map_fetch_ctrl
    import map_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [SCR_W-1:0]  sx,
    input  logic [SCR_W-1:0]  sy,
    input  logic              de,
    output logic [MAP_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [CODE_W-1:0] ram_wdata,
    input  logic [CODE_W-1:0] ram_rdata,
    input  logic              wr_req,
    input  logic [MAP_AW-1:0] wr_addr,
    input  logic [CODE_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              init_start,
    input  logic [CODE_W-1:0] init_code,
    output logic              init_done,
    output logic [CODE_W-1:0] spr_code,
    output logic [SUB_W-1:0]  spr_x,
    output logic [SUB_W-1:0]  spr_y,
    output logic              spr_valid
);

    fetch_state_e      state;
    logic [MAP_AW-1:0] fill_cnt;
    logic [CODE_W-1:0] fill_code;
    logic [CODE_W-1:0] code_q;
    pix_t              pix_q;

    logic in_map;
    logic rd_slot;
    logic free_slot;

    assign in_map    = (sx < MAP_W_PX) && (sy < MAP_H_PX);
    assign rd_slot   = de && in_map && (sx[SUB_W-1:0] == '0);
    assign free_slot = !rd_slot;

    // RAM port mux; reset blanks the port so nothing leaks out while rst is held.
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        wr_ack    = 1'b0;
        if (!rst) begin
            if (rd_slot) begin
                ram_addr = tile_addr(sy[SUB_W+ROW_W-1:SUB_W], sx[SUB_W+COL_W-1:SUB_W]);
            end else if (state == ST_INIT) begin
                ram_addr  = fill_cnt;
                ram_we    = 1'b1;
                ram_wdata = fill_code;
            end else if (wr_req) begin
                ram_addr  = wr_addr;
                ram_we    = 1'b1;
                ram_wdata = wr_data;
                wr_ack    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            fill_cnt  <= '0;
            fill_code <= '0;
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (init_start) begin
                        state     <= ST_INIT;
                        fill_cnt  <= '0;
                        fill_code <= init_code;
                    end
                end
                ST_INIT: begin
                    if (free_slot) begin
                        fill_cnt <= fill_cnt + MAP_AW'(1);
                        if (fill_cnt == '1) begin
                            state     <= ST_RUN;
                            init_done <= 1'b1;
                        end
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // Stage 1 tracks the pixel while the RAM read is in flight; stage 2 captures the code.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_q     <= '0;
            code_q    <= EMPTY;
            spr_code  <= EMPTY;
            spr_x     <= '0;
            spr_y     <= '0;
            spr_valid <= 1'b0;
        end else begin
            pix_q <= '{x: sx[SUB_W-1:0], y: sy[SUB_W-1:0], vld: in_map && de, rd: rd_slot};
            if (pix_q.rd) begin
                code_q <= ram_rdata;
            end
            spr_x     <= pix_q.x;
            spr_y     <= pix_q.y;
            spr_valid <= pix_q.vld;
            if (!pix_q.vld) begin
                spr_code <= EMPTY;
            end else if (pix_q.rd) begin
                spr_code <= ram_rdata;
            end else begin
                spr_code <= code_q;
            end
        end
    end

endmodule

// File: tb/tb_map_fetch_ctrl.sv
// Directed bench for map_fetch_ctrl with a behavioural 1024x4 tile RAM beside the DUT.
module tb_map_fetch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] sx, sy;
    logic       de;
    logic [9:0] ram_addr;
    logic       ram_we;
    logic [3:0] ram_wdata;
    logic [3:0] ram_rdata = 4'h0;
    logic       wr_req;
    logic [9:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_ack;
    logic       init_start;
    logic [3:0] init_code;
    logic       init_done;
    logic [3:0] spr_code;
    logic [2:0] spr_x, spr_y;
    logic       spr_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    map_fetch_ctrl dut (
        .clk(clk), .rst(rst), .sx(sx), .sy(sy), .de(de),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .init_start(init_start), .init_code(init_code), .init_done(init_done),
        .spr_code(spr_code), .spr_x(spr_x), .spr_y(spr_y), .spr_valid(spr_valid)
    );

    // External tile RAM model: synchronous write, 1-cycle registered read.
    logic [3:0] mem [1024] = '{default: 4'h0};
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Traffic monitor: write/ack/done counters and fill address sequencing.
    int         wr_cnt = 0;
    int         ack_cnt = 0;
    int         done_cnt = 0;
    int         addr_err = 0;
    logic       mon_init = 1'b0;
    logic [9:0] exp_addr = 10'd0;
    always @(posedge clk) begin
        if (ram_we) wr_cnt <= wr_cnt + 1;
        if (wr_ack) ack_cnt <= ack_cnt + 1;
        if (init_done) done_cnt <= done_cnt + 1;
        if (!mon_init) exp_addr <= 10'd0;
        else if (ram_we) begin
            if (ram_addr !== exp_addr) addr_err <= addr_err + 1;
            exp_addr <= exp_addr + 10'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; sx = '0; sy = '0; de = 1'b0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0; init_start = 1'b0; init_code = '0;
        tick(); tick();
        checks++; if (spr_valid !== 1'b0) begin errors++; $display("FAIL reset_spr_valid got %0h want 0", spr_valid); end
        checks++; if (spr_code !== 4'h0) begin errors++; $display("FAIL reset_spr_code got %0h want 0", spr_code); end
        checks++; if ({spr_x, spr_y} !== 6'h0) begin errors++; $display("FAIL reset_spr_xy got %0h want 0", {spr_x, spr_y}); end
        checks++; if ({wr_ack, init_done, ram_we} !== 3'b000) begin errors++; $display("FAIL reset_strobes got %b want 000", {wr_ack, init_done, ram_we}); end
        checks++; if ({ram_addr, ram_wdata} !== 14'h0) begin errors++; $display("FAIL reset_ram_port got %0h want 0", {ram_addr, ram_wdata}); end
        rst = 1'b0;
        tick();
        checks++; if ({ram_we, wr_ack, ram_addr} !== 12'h0) begin errors++; $display("FAIL idle_after_reset got %0h want 0", {ram_we, wr_ack, ram_addr}); end
    endtask

    task automatic test_pixel_timing();
        logic [3:0] ecode;
        logic [2:0] ex;
        // Preload tile 33 during blanking.
        de = 1'b0; wr_req = 1'b1; wr_addr = 10'd33; wr_data = 4'h5;
        #1;
        checks++; if ({wr_ack, ram_we, ram_addr} !== {2'b11, 10'd33}) begin errors++; $display("FAIL preload_grant got %0h want %0h", {wr_ack, ram_we, ram_addr}, {2'b11, 10'd33}); end
        tick();
        wr_req = 1'b0;
        de = 1'b1; sy = 10'd8;
        for (int j = 0; j < 12; j++) begin
            if (j < 10) sx = 10'(8 + j);
            else begin de = 1'b0; sx = '0; sy = '0; end
            #1;
            if (j == 0) begin
                checks++; if ({ram_we, ram_addr} !== {1'b0, 10'd33}) begin errors++; $display("FAIL read_slot_addr got %0h want %0h", {ram_we, ram_addr}, {1'b0, 10'd33}); end
            end
            if (j == 1) begin
                checks++; if (ram_addr !== 10'd0) begin errors++; $display("FAIL non_slot_addr got %0d want 0", ram_addr); end
            end
            if (j >= 2) begin
                ecode = (j - 2 < 8) ? 4'h5 : 4'h0;
                ex = 3'((j - 2) % 8);
                checks++;
                if ({spr_valid, spr_code, spr_x, spr_y} !== {1'b1, ecode, ex, 3'd0}) begin
                    errors++;
                    $display("FAIL pixel_%0d got v=%b c=%0h x=%0d y=%0d want v=1 c=%0h x=%0d y=0", j - 2, spr_valid, spr_code, spr_x, spr_y, ecode, ex);
                end
            end
            tick();
        end
        checks++; if ({spr_valid, spr_code} !== 5'h0) begin errors++; $display("FAIL blank_pixel got %0h want 0", {spr_valid, spr_code}); end
    endtask

    task automatic test_write_blocking();
        de = 1'b1; sy = 10'd8; sx = 10'd24;
        wr_req = 1'b1; wr_addr = 10'd100; wr_data = 4'h2;
        #1;
        checks++; if ({wr_ack, ram_we, ram_addr} !== {2'b00, 10'd35}) begin errors++; $display("FAIL blocked_in_read_slot got %0h want %0h", {wr_ack, ram_we, ram_addr}, {2'b00, 10'd35}); end
        tick();
        sx = 10'd25;
        #1;
        checks++; if ({wr_ack, ram_we, ram_addr, ram_wdata} !== {2'b11, 10'd100, 4'h2}) begin errors++; $display("FAIL grant_after_slot got %0h want %0h", {wr_ack, ram_we, ram_addr, ram_wdata}, {2'b11, 10'd100, 4'h2}); end
        tick();
        wr_req = 1'b0; de = 1'b0; sx = '0; sy = '0;
        #1;
        checks++; if (mem[100] !== 4'h2) begin errors++; $display("FAIL blocked_write_data got %0h want 2", mem[100]); end
    endtask

    task automatic test_back_to_back();
        int a0;
        a0 = ack_cnt;
        de = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wr_req = 1'b1; wr_addr = 10'(200 + k); wr_data = 4'(7 + k);
            #1;
            checks++;
            if ({wr_ack, ram_we, ram_addr, ram_wdata} !== {2'b11, 10'(200 + k), 4'(7 + k)}) begin
                errors++;
                $display("FAIL b2b_grant_%0d got %0h want %0h", k, {wr_ack, ram_we, ram_addr, ram_wdata}, {2'b11, 10'(200 + k), 4'(7 + k)});
            end
            tick();
        end
        wr_req = 1'b0;
        #1;
        checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL b2b_ack_drop got %b want 0", wr_ack); end
        checks++; if (ack_cnt - a0 !== 3) begin errors++; $display("FAIL b2b_ack_count got %0d want 3", ack_cnt - a0); end
        checks++; if ({mem[200], mem[201], mem[202]} !== 12'h789) begin errors++; $display("FAIL b2b_ram got %0h want 789", {mem[200], mem[201], mem[202]}); end
    endtask

    task automatic test_out_of_map();
        de = 1'b1; sy = 10'd8; sx = 10'd8;
        tick();
        sx = 10'd300; wr_req = 1'b1; wr_addr = 10'd300; wr_data = 4'h6;
        #1;
        checks++; if ({wr_ack, ram_we, ram_addr} !== {2'b11, 10'd300}) begin errors++; $display("FAIL offmap_grant got %0h want %0h", {wr_ack, ram_we, ram_addr}, {2'b11, 10'd300}); end
        tick();
        wr_req = 1'b0; sx = 10'd301;
        #1;
        checks++; if ({spr_valid, spr_code} !== 5'h15) begin errors++; $display("FAIL inmap_before_offmap got %0h want 15", {spr_valid, spr_code}); end
        tick();
        checks++; if ({spr_valid, spr_code} !== 5'h0) begin errors++; $display("FAIL offmap_pixel got %0h want 0", {spr_valid, spr_code}); end
        de = 1'b0; sx = '0; sy = '0;
        tick();
    endtask

    task automatic test_init();
        int w0, a0, d0, n, bad, ack_in_init;
        w0 = wr_cnt; a0 = ack_cnt; d0 = done_cnt; n = 0; bad = 0; ack_in_init = 0;
        mon_init = 1'b1;
        de = 1'b0; init_start = 1'b1; init_code = 4'h3;
        tick();
        init_start = 1'b0; init_code = 4'h0;
        wr_req = 1'b1; wr_addr = 10'd5; wr_data = 4'hF;
        for (int i = 1; i <= 1100; i++) begin
            init_start = (i == 500);
            init_code = (i == 500) ? 4'h9 : 4'h0;
            #1;
            if (wr_ack !== 1'b0) ack_in_init++;
            tick();
            if (init_done === 1'b1) begin
                n = i;
                wr_req = 1'b0;
                break;
            end
        end
        init_start = 1'b0;
        checks++; if (n !== 1024) begin errors++; $display("FAIL init_done_cycle got %0d want 1024", n); end
        checks++; if (wr_cnt - w0 !== 1024) begin errors++; $display("FAIL init_write_count got %0d want 1024", wr_cnt - w0); end
        checks++; if (addr_err !== 0) begin errors++; $display("FAIL init_addr_sequence got %0d errors want 0", addr_err); end
        checks++; if (ack_in_init !== 0 || ack_cnt !== a0) begin errors++; $display("FAIL init_no_ack got %0d want 0", ack_in_init + ack_cnt - a0); end
        tick();
        mon_init = 1'b0;
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL init_done_pulse got %b want 0", init_done); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL init_done_count got %0d want 1", done_cnt - d0); end
        for (int a = 0; a < 1024; a++) if (mem[a] !== 4'h3) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL init_ram_fill got %0d bad words want 0", bad); end
    endtask

    task automatic test_reset_mid_init();
        int w0, w1, d1;
        logic reached;
        reached = 1'b0;
        w0 = wr_cnt;
        de = 1'b0; init_start = 1'b1; init_code = 4'hA;
        tick();
        init_start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (wr_cnt - w0 >= 200) begin reached = 1'b1; break; end
        end
        checks++; if (reached !== 1'b1) begin errors++; $display("FAIL midinit_progress got %0d writes want 200", wr_cnt - w0); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        w1 = wr_cnt; d1 = done_cnt;
        #1;
        checks++;
        if ({ram_we, ram_addr, ram_wdata, wr_ack, init_done, spr_valid, spr_code} !== 21'h0) begin
            errors++;
            $display("FAIL midinit_outputs got %0h want 0", {ram_we, ram_addr, ram_wdata, wr_ack, init_done, spr_valid, spr_code});
        end
        for (int i = 0; i < 50; i++) tick();
        checks++; if (wr_cnt !== w1) begin errors++; $display("FAIL midinit_no_resume got %0d writes want 0", wr_cnt - w1); end
        checks++; if (done_cnt !== d1) begin errors++; $display("FAIL midinit_no_done got %0d want 0", done_cnt - d1); end
        wr_req = 1'b1; wr_addr = 10'd7; wr_data = 4'h1;
        #1;
        checks++; if ({wr_ack, ram_addr} !== {1'b1, 10'd7}) begin errors++; $display("FAIL midinit_run_state got %0h want %0h", {wr_ack, ram_addr}, {1'b1, 10'd7}); end
        tick();
        wr_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pixel_timing();
        test_write_blocking();
        test_back_to_back();
        test_out_of_map();
        test_init();
        test_reset_mid_init();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
